// File: rtl/tc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package tc_fetch_pkg;

    // Bytes per instruction word; also the default PC increment.
    localparam int INSTR_BYTES = 4;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // Byte-packing order of an instruction: the byte at the fetched address
    // (b0) lands in bits [7:0], the byte at address+3 in bits [31:24].
    function automatic logic [31:0] pack_instr(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/tc_fetch_unit_skid.sv
// One-entry holding register for an instruction word and its PC.
// clear has priority over load, which has priority over drain.
module tc_skid_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              vld,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] pc
);

    // Occupancy flag: emptied by reset or flush, set by a load, cleared by a drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld <= 1'b0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
        end else if (drain) begin
            vld <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while vld is set.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
            pc   <= load_pc;
        end
    end

endmodule

// File: rtl/tc_fetch_unit.sv
// Program counter and fetch sequencer in front of a 1-cycle-latency,
// 4-byte-wide program ROM. Delivers whole instructions to the decoder,
// handles jumps, halt and decoder backpressure without losing or
// duplicating a word.
//
// Handshake (out_valid/out_ready): an instruction transfers on a rising edge
// where both are 1. While out_valid is 1 and the word has not transferred,
// out_instr/out_pc hold the same word; only a jump or reset may withdraw it.
module tc_fetch_unit
    import tc_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                STEP     = INSTR_BYTES,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [7:0]        rom_in0,
    input  logic [7:0]        rom_in1,
    input  logic [7:0]        rom_in2,
    input  logic [7:0]        rom_in3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt_req,
    output logic              halted,
    output fetch_state_e      fsm_state
);

    localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [ADDR_W-1:0] pc_q;
    logic              rom_vld;
    logic [ADDR_W-1:0] rom_pc;
    logic [31:0]       rom_word;

    logic              buf_vld;
    logic [31:0]       buf_instr;
    logic [ADDR_W-1:0] buf_pc;
    logic              buf_load;
    logic              buf_drain;
    logic              buf_vld_next;
    logic              issue;

    assign rom_address = pc_q;
    assign rom_word    = pack_instr(rom_in0, rom_in1, rom_in2, rom_in3);

    // The buffer, when occupied, always holds the older word, so it wins the mux.
    assign out_valid = buf_vld | rom_vld;
    assign out_instr = buf_vld ? buf_instr : rom_word;
    assign out_pc    = buf_vld ? buf_pc    : rom_pc;

    // A ROM word that cannot leave this cycle (decoder stalled, or the
    // buffer ahead of it) is parked in the buffer; a draining buffer
    // refills from the ROM word behind it.
    assign buf_load     = rom_vld && (buf_vld || !out_ready);
    assign buf_drain    = buf_vld && out_ready;
    assign buf_vld_next = buf_load || (buf_vld && !out_ready);

    // Only fetch when nothing will be left waiting; this is what keeps a new
    // ROM word from arriving while the buffer is full and stalled.
    assign issue = (state == ST_RUN) && !halt_req && !buf_vld_next && !jump_en;

    assign halted    = (state == ST_HALTED);
    assign fsm_state = state;

    tc_skid_reg #(
        .DATA_W (32),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (jump_en),
        .load      (buf_load),
        .drain     (buf_drain),
        .load_data (rom_word),
        .load_pc   (rom_pc),
        .vld       (buf_vld),
        .data      (buf_instr),
        .pc        (buf_pc)
    );

    // State register, PC and in-flight flag; a jump flushes the ROM stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_RUN;
            pc_q    <= RESET_PC;
            rom_vld <= 1'b0;
        end else begin
            state <= state_next;
            if (jump_en) begin
                pc_q    <= jump_target;
                rom_vld <= 1'b0;
            end else begin
                rom_vld <= issue;
                if (issue) begin
                    pc_q <= pc_q + STEP_INC;
                end
            end
        end
    end

    // PC of the word the ROM is presenting next cycle; meaningful only with rom_vld.
    always_ff @(posedge clk) begin
        rom_pc <= pc_q;
    end

    // Next-state logic: halt drains in-flight words before stopping; a jump always resumes RUN.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (halt_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_next = ST_RUN;
                end else if (!rom_vld && !buf_vld) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        if (jump_en) begin
            state_next = ST_RUN;
        end
    end

endmodule

// File: tb/tb_tc_fetch_unit.sv
// Self-checking bench for tc_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based behavioural model of the fetch stream.
module tb_tc_fetch_unit;
    import tc_fetch_pkg::*;

    localparam int          ADDR_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          M_RUN    = 0;
    localparam int          M_DRAIN  = 1;
    localparam int          M_HALTED = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] rom_address;
    logic [7:0]        rom_in0, rom_in1, rom_in2, rom_in3;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              jump_en = 1'b0;
    logic [ADDR_W-1:0] jump_target = '0;
    logic              halt_req = 1'b0;
    logic              halted;
    fetch_state_e      fsm_state;

    tc_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .STEP     (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_address (rom_address),
        .rom_in0     (rom_in0),
        .rom_in1     (rom_in1),
        .rom_in2     (rom_in2),
        .rom_in3     (rom_in3),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .halt_req    (halt_req),
        .halted      (halted),
        .fsm_state   (fsm_state)
    );

    // Full-size ROM with mem[a] = a[7:0], registered read, active-high reset = ~rst.
    always @(posedge clk) begin
        if (!rst) begin
            rom_in0 <= 8'h00;
            rom_in1 <= 8'h00;
            rom_in2 <= 8'h00;
            rom_in3 <= 8'h00;
        end else begin
            rom_in0 <= rom_address[7:0];
            rom_in1 <= rom_address[7:0] + 8'd1;
            rom_in2 <= rom_address[7:0] + 8'd2;
            rom_in3 <= rom_address[7:0] + 8'd3;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction the ROM holds at pc: bytes pc, pc+1, pc+2, pc+3 (low byte first).
    function automatic logic [31:0] exp_instr(input logic [15:0] pc);
        logic [7:0] b;
        b = pc[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // Behavioural model: exp_q holds the PCs of fetched, not-yet-delivered
    // words, oldest first; its head is what the decoder must see.
    logic [15:0] exp_q[$];
    logic [15:0] m_fetch_pc;
    int          m_mode;

    task automatic model_step();
        bit consumed;
        bit left_waiting;
        bit fetch;
        int nxt;
        if (!rst) begin
            exp_q.delete();
            m_fetch_pc = RESET_PC;
            m_mode     = M_RUN;
            return;
        end
        consumed     = (exp_q.size() > 0) && out_ready;
        left_waiting = (exp_q.size() - (consumed ? 1 : 0)) > 0;
        fetch        = (m_mode == M_RUN) && !halt_req && !jump_en && !left_waiting;
        nxt = m_mode;
        if (jump_en) begin
            nxt = M_RUN;
        end else if (m_mode == M_RUN && halt_req) begin
            nxt = M_DRAIN;
        end else if (m_mode == M_DRAIN) begin
            if (!halt_req) nxt = M_RUN;
            else if (exp_q.size() == 0) nxt = M_HALTED;
        end
        if (consumed) void'(exp_q.pop_front());
        if (jump_en) begin
            exp_q.delete();
            m_fetch_pc = jump_target;
        end else if (fetch) begin
            exp_q.push_back(m_fetch_pc);
            m_fetch_pc = m_fetch_pc + 16'd4;
        end
        m_mode = nxt;
    endtask

    always @(posedge clk) model_step();

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("rom_address", 32'(rom_address), 32'(m_fetch_pc));
            check("halted", 32'(halted), 32'(m_mode == M_HALTED));
            if (exp_q.size() > 0) begin
                check("out_pc", 32'(out_pc), 32'(exp_q[0]));
                check("out_instr", out_instr, exp_instr(exp_q[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Literal expectation for the word on the output; pins both DUT and model.
    task automatic pin_out(input string name, input logic [15:0] pc, input logic [31:0] instr);
        logic [15:0] m_pc;
        m_pc = (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_pc"}, 32'(out_pc), 32'(pc));
        check({name, "_instr"}, out_instr, instr);
        check({name, "_model_pc"}, 32'(m_pc), 32'(pc));
        check({name, "_model_instr"}, exp_instr(m_pc), instr);
    endtask

    task automatic pin_idle(input string name, input logic [15:0] addr);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        check({name, "_addr"}, 32'(rom_address), 32'(addr));
        check({name, "_model_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int delivered;
    int waited;

    initial begin
        // Reset held low for 2 cycles.
        cyc(1);
        checking = 1'b1;
        cyc(1);
        pin_idle("reset", RESET_PC);
        check("reset_halted", 32'(halted), 32'd0);

        // Release: one word per cycle from RESET_PC.
        rst = 1'b1;
        cyc(1);
        pin_out("first", 16'h0000, 32'h03020100);
        cyc(1);
        pin_out("second", 16'h0004, 32'h07060504);

        // Backpressure for 3 cycles while 0x0004 is shown.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            pin_out("stall", 16'h0004, 32'h07060504);
            check("stall_addr", 32'(rom_address), 32'h0008);
        end
        out_ready = 1'b1;
        cyc(1);
        pin_out("resume0", 16'h0008, 32'h0B0A0908);
        cyc(1);
        pin_out("resume1", 16'h000C, 32'h0F0E0D0C);

        // Park 0x000C in the buffer, then reset for one cycle.
        out_ready = 1'b0;
        cyc(1);
        pin_out("parked", 16'h000C, 32'h0F0E0D0C);
        rst = 1'b0;
        cyc(1);
        pin_idle("midreset", RESET_PC);
        rst = 1'b1;
        out_ready = 1'b1;
        cyc(1);
        pin_out("restart", 16'h0000, 32'h03020100);
        cyc(1);
        pin_out("restart1", 16'h0004, 32'h07060504);

        // Jump while 0x0008 is being fetched.
        jump_en = 1'b1;
        jump_target = 16'h0040;
        cyc(1);
        jump_en = 1'b0;
        pin_idle("jump_gap", 16'h0040);
        cyc(1);
        pin_out("jump_dest", 16'h0040, 32'h43424140);

        // Wrap across the top of the address space.
        jump_en = 1'b1;
        jump_target = 16'hFFF8;
        cyc(1);
        jump_en = 1'b0;
        cyc(1);
        pin_out("wrap0", 16'hFFF8, 32'hFBFAF9F8);
        cyc(1);
        pin_out("wrap1", 16'hFFFC, 32'hFFFEFDFC);
        cyc(1);
        pin_out("wrap2", 16'h0000, 32'h03020100);
        cyc(1);
        pin_out("wrap3", 16'h0004, 32'h07060504);

        // Halt in steady state.
        halt_req = 1'b1;
        delivered = 0;
        waited = 0;
        while (!halted && waited < 20) begin
            if (out_valid && out_ready) delivered++;
            cyc(1);
            waited++;
        end
        check("halt_reached", 32'(halted), 32'd1);
        check("halt_delivered_le2", 32'(delivered <= 2), 32'd1);
        cyc(3);
        check("halt_still", 32'(halted), 32'd1);
        pin_idle("halt_frozen", 16'h0008);

        // Jump out of HALTED with halt_req still high on the jump edge.
        jump_en = 1'b1;
        jump_target = 16'h0010;
        cyc(1);
        jump_en = 1'b0;
        halt_req = 1'b0;
        check("unhalt", 32'(halted), 32'd0);
        cyc(1);
        pin_out("unhalt_dest", 16'h0010, 32'h13121110);

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            jump_en   = ($urandom_range(0, 40) == 0);
            case ($urandom_range(0, 3))
                0: jump_target = 16'($urandom) & 16'hFFFC;
                1: jump_target = 16'hFFF0 | (16'($urandom_range(0, 3)) << 2);
                2: jump_target = 16'($urandom);
                default: jump_target = 16'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 60) == 0) halt_req = ~halt_req;
            rst = ($urandom_range(0, 300) != 0);
            cyc(1);
        end
        rst = 1'b1;
        jump_en = 1'b0;
        halt_req = 1'b0;
        out_ready = 1'b1;
        cyc(4);
        checking = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the run is bounded by fixed loops, this only guards against a stuck simulator.
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
